// File: rtl/flash_byte_reader.sv
// flash_byte_reader: wakes the SPI flash with 0xAB, then reads a window of
// bytes forever with READ (0x03), holding each byte on led_set between reads.
module flash_byte_reader #(
  parameter int unsigned CLK_DIV     = 6,
  parameter logic [23:0] START_ADDR  = 24'h100000,
  parameter int unsigned NUM_BYTES   = 16,
  parameter int unsigned HOLD_CYCLES = 12000000,
  parameter int unsigned WAKE_WAIT   = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] led_set,
  output logic       byte_valid,
  output logic       busy
);

  // state       | meaning
  // S_WAKE_CMD  | 8-bit transaction shifting out 0xAB
  // S_WAKE_WAIT | CS high for WAKE_WAIT cycles (tRES)
  // S_XFER      | 40-bit READ of the current byte
  // S_HOLD      | CS high for HOLD_CYCLES, byte on display
  typedef enum logic [1:0] {
    S_WAKE_CMD,
    S_WAKE_WAIT,
    S_XFER,
    S_HOLD
  } state_e;

  localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned TMAX = (HOLD_CYCLES > WAKE_WAIT) ? HOLD_CYCLES : WAKE_WAIT;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(WAKE_WAIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BYTES - 1);

  state_e        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bits_q, bits_d;
  logic [38:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    led_q, led_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic          start;
  logic [23:0]   addr;
  logic [39:0]   word;
  logic [5:0]    last_bit;

  // Next-state logic: CS-high timers, SCK divider, MOSI shift-out, MISO capture.
  always_comb begin
    state_d  = state_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    div_d    = div_q;
    bits_d   = bits_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    led_d    = led_q;
    valid_d  = 1'b0;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    start    = 1'b0;

    addr = START_ADDR + 24'(idx_q);
    if (state_q == S_WAKE_CMD) begin
      word     = {8'hAB, 32'h0};
      last_bit = 6'd8;
    end else begin
      word     = {8'h03, addr, 8'h00};
      last_bit = 6'd40;
    end

    // CS-high phases end by launching the next transaction on the same edge,
    // so the high time is exactly the timer length.
    case (state_q)
      S_WAKE_CMD: begin
        if (cs_n_q) start = 1'b1;
      end
      S_WAKE_WAIT, S_HOLD: begin
        if (tmr_q == '0) begin
          start   = 1'b1;
          state_d = S_XFER;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: ;
    endcase

    if (start) begin
      cs_n_d = 1'b0;
      sck_d  = 1'b0;
      mosi_d = word[39];
      tx_d   = word[38:0];
      div_d  = DIV_LOAD;
      bits_d = '0;
    end else if (!cs_n_q) begin
      if (div_q != '0) begin
        div_d = div_q - DW'(1);
      end else begin
        div_d = DIV_LOAD;
        if (!sck_q) begin
          sck_d  = 1'b1;
          bits_d = bits_q + 6'd1;
          // Data byte occupies rising edges 33..40 of the read.
          if (state_q == S_XFER && bits_q >= 6'd32) rx_d = {rx_q[6:0], spi_miso};
        end else begin
          sck_d = 1'b0;
          if (bits_q == last_bit) begin
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
            if (state_q == S_XFER) begin
              led_d   = rx_q;
              valid_d = 1'b1;
              idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
              state_d = S_HOLD;
              tmr_d   = HOLD_LOAD;
            end else begin
              state_d = S_WAKE_WAIT;
              tmr_d   = WAIT_LOAD;
            end
          end else begin
            mosi_d = tx_q[38];
            tx_d   = {tx_q[37:0], 1'b0};
          end
        end
      end
    end
  end

  // State registers; reset forces CS high immediately, aborting any command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAKE_CMD;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      div_q   <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      led_q   <= 8'hFF;
      valid_q <= 1'b0;
      idx_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      led_q   <= led_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
    end
  end

  assign spi_cs_n   = cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign led_set    = led_q;
  assign byte_valid = valid_q;
  assign busy       = ~cs_n_q;

endmodule

// File: tb/tb_flash_byte_reader.sv
// Bench for flash_byte_reader: a behavioural SPI flash per instance, a
// protocol watcher, and a scoreboard of expected transactions.
module tb_flash_byte_reader;

  localparam int unsigned CLK_DIV = 2;

  typedef struct {
    int          nbits;
    logic [39:0] word;
    bit          is_rd;
    logic [7:0]  led;
    int          t_fall;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] cs_n, sck, mosi, byte_valid, busy;
  logic [1:0] miso = 2'b00;
  logic [1:0][7:0] led;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flash_byte_reader #(
    .CLK_DIV(CLK_DIV), .START_ADDR(24'h100000), .NUM_BYTES(3),
    .HOLD_CYCLES(20), .WAKE_WAIT(10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .spi_cs_n(cs_n[0]), .spi_sck(sck[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]), .led_set(led[0]),
    .byte_valid(byte_valid[0]), .busy(busy[0])
  );

  flash_byte_reader #(
    .CLK_DIV(CLK_DIV), .START_ADDR(24'h100000), .NUM_BYTES(1),
    .HOLD_CYCLES(20), .WAKE_WAIT(10)
  ) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .spi_cs_n(cs_n[1]), .spi_sck(sck[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]), .led_set(led[1]),
    .byte_valid(byte_valid[1]), .busy(busy[1])
  );

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    case (a)
      24'h100000: return 8'hA5;
      24'h100001: return 8'h3C;
      24'h100002: return 8'h5A;
      default:    return a[7:0] ^ 8'h77;
    endcase
  endfunction

  // Flash model: shifts in MOSI on SCK rise, drives the data byte on SCK fall,
  // logs each completed CS-low window.
  logic [1:0]  cs_p = 2'b11, sck_p = 2'b00;
  int          fl_cnt [2] = '{0, 0};
  logic [39:0] fl_sh [2] = '{40'h0, 40'h0};
  logic [7:0]  fl_dat [2] = '{8'h0, 8'h0};
  int          xact_cnt [2] = '{0, 0};
  int          xact_bits [2] = '{0, 0};
  logic [39:0] xact_word [2] = '{40'h0, 40'h0};
  int          fall_cyc [2] = '{0, 0};
  int          rise_cyc [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_n[k] && !cs_p[k]) begin
        xact_bits[k] = fl_cnt[k];
        xact_word[k] = fl_sh[k];
        rise_cyc[k]  = cyc;
        xact_cnt[k]  = xact_cnt[k] + 1;
      end
      if (!cs_n[k] && cs_p[k]) begin
        fl_cnt[k]   = 0;
        fl_sh[k]    = '0;
        fall_cyc[k] = cyc;
      end
      if (!cs_n[k]) begin
        if (sck[k] && !sck_p[k]) begin
          fl_sh[k]  = {fl_sh[k][38:0], mosi[k]};
          fl_cnt[k] = fl_cnt[k] + 1;
          if (fl_cnt[k] == 32) fl_dat[k] = mem_rd(fl_sh[k][23:0]);
        end else if (!sck[k] && sck_p[k] && fl_cnt[k] >= 32 && fl_cnt[k] < 40) begin
          miso[k] = fl_dat[k][39 - fl_cnt[k]];
        end
      end
      cs_p[k]  = cs_n[k];
      sck_p[k] = sck[k];
    end
  end

  // Protocol watcher over both instances; violations are tallied here and
  // judged once at the end.
  int         proto_bad = 0;
  logic [1:0] pk_sck = 2'b00, pk_mosi = 2'b00, pk_bv = 2'b00;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sck[k] && pk_sck[k] && mosi[k] !== pk_mosi[k]) begin
        proto_bad = proto_bad + 1;
        $display("protocol: inst%0d mosi moved while sck high, cycle %0d", k, cyc);
      end
      if (cs_n[k] && sck[k]) begin
        proto_bad = proto_bad + 1;
        $display("protocol: inst%0d sck high while cs high, cycle %0d", k, cyc);
      end
      if (busy[k] !== ~cs_n[k]) begin
        proto_bad = proto_bad + 1;
        $display("protocol: inst%0d busy not inverse of cs_n, cycle %0d", k, cyc);
      end
      if (byte_valid[k] && pk_bv[k]) begin
        proto_bad = proto_bad + 1;
        $display("protocol: inst%0d byte_valid high two cycles, cycle %0d", k, cyc);
      end
      pk_sck[k]  = sck[k];
      pk_mosi[k] = mosi[k];
      pk_bv[k]   = byte_valid[k];
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int nbits, input logic [39:0] word, input bit is_rd,
                      input logic [7:0] ledv, input int t_fall);
    exp_t e;
    e.nbits  = nbits;
    e.word   = word;
    e.is_rd  = is_rd;
    e.led    = ledv;
    e.t_fall = t_fall;
    sb.push_back(e);
  endtask

  task automatic check_reset(input int k, input string tag);
    chk({tag, " cs_n"}, 40'(cs_n[k]), 40'd1);
    chk({tag, " sck"}, 40'(sck[k]), 40'd0);
    chk({tag, " mosi"}, 40'(mosi[k]), 40'd0);
    chk({tag, " led_set"}, 40'(led[k]), 40'hFF);
    chk({tag, " byte_valid"}, 40'(byte_valid[k]), 40'd0);
    chk({tag, " busy"}, 40'(busy[k]), 40'd0);
  endtask

  // Pops each expected transaction and waits (bounded) for the flash model to
  // see the matching CS-low window end. Times are cycles after reset release.
  task automatic run_sb(input int k, input int c0);
    exp_t e;
    int   base;
    bit   seen;
    int   i = 0;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      base = xact_cnt[k];
      seen = 1'b0;
      for (int n = 0; n < 1000 && !seen; n++) begin
        @(negedge clk);
        #1;
        if (xact_cnt[k] != base) seen = 1'b1;
      end
      chk($sformatf("inst%0d xact%0d completes", k, i), 40'(seen), 40'd1);
      if (seen) begin
        chk($sformatf("inst%0d xact%0d bits", k, i), 40'(xact_bits[k]), 40'(e.nbits));
        chk($sformatf("inst%0d xact%0d mosi word", k, i), xact_word[k], e.word);
        chk($sformatf("inst%0d xact%0d cs fall cycle", k, i),
            40'(fall_cyc[k] - c0 - 1), 40'(e.t_fall));
        chk($sformatf("inst%0d xact%0d cs rise cycle", k, i),
            40'(rise_cyc[k] - c0 - 1), 40'(e.t_fall + 2 * e.nbits * int'(CLK_DIV)));
        chk($sformatf("inst%0d xact%0d busy at end", k, i), 40'(busy[k]), 40'd0);
        if (e.is_rd) begin
          chk($sformatf("inst%0d xact%0d led_set", k, i), 40'(led[k]), 40'(e.led));
          chk($sformatf("inst%0d xact%0d byte_valid", k, i), 40'(byte_valid[k]), 40'd1);
        end else begin
          chk($sformatf("inst%0d xact%0d no byte_valid on wake", k, i),
              40'(byte_valid[k]), 40'd0);
        end
      end
      i++;
    end
  endtask

  initial begin
    int  c0;
    bit  hit;

    repeat (3) @(negedge clk);
    #1;
    check_reset(0, "A reset");
    check_reset(1, "B reset");

    // Wake, then wrap across a 3-byte window: 42 = 16*2+10, period 180 = 80*2+20.
    @(negedge clk);
    c0 = cyc;
    rst_n[0] = 1'b1;
    push(8,  {32'h0, 8'hAB},             1'b0, 8'h00, 0);
    push(40, {8'h03, 24'h100000, 8'h00}, 1'b1, 8'hA5, 42);
    push(40, {8'h03, 24'h100001, 8'h00}, 1'b1, 8'h3C, 222);
    push(40, {8'h03, 24'h100002, 8'h00}, 1'b1, 8'h5A, 402);
    push(40, {8'h03, 24'h100000, 8'h00}, 1'b1, 8'hA5, 582);
    run_sb(0, c0);

    // Reset in the middle of the next read, after the 20th SCK rise.
    hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (!cs_n[0] && fl_cnt[0] == 20) hit = 1'b1;
    end
    chk("A reached 20th sck rise", 40'(hit), 40'd1);
    chk("A led before mid reset", 40'(led[0]), 40'hA5);
    rst_n[0] = 1'b0;
    #1;
    check_reset(0, "A mid reset");
    repeat (3) @(negedge clk);
    c0 = cyc;
    rst_n[0] = 1'b1;
    push(8,  {32'h0, 8'hAB},             1'b0, 8'h00, 0);
    push(40, {8'h03, 24'h100000, 8'h00}, 1'b1, 8'hA5, 42);
    run_sb(0, c0);

    // Single-byte window: same address and same byte every read.
    @(negedge clk);
    c0 = cyc;
    rst_n[1] = 1'b1;
    push(8,  {32'h0, 8'hAB},             1'b0, 8'h00, 0);
    push(40, {8'h03, 24'h100000, 8'h00}, 1'b1, 8'hA5, 42);
    push(40, {8'h03, 24'h100000, 8'h00}, 1'b1, 8'hA5, 222);
    push(40, {8'h03, 24'h100000, 8'h00}, 1'b1, 8'hA5, 402);
    run_sb(1, c0);

    repeat (4) @(negedge clk);
    chk("protocol violations", 40'(proto_bad), 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_byte_reader.md
# flash_byte_reader

Upstream feeder for the LED driver in the flashSPI design. The block wakes the on-board SPI flash, then reads a window of bytes one at a time using the standard READ (0x03) command. Each byte is presented on `led_set` for a fixed display interval before the next is fetched, and the block wraps to the start of the window forever. `led_set` connects directly to the LED driver's `led_set` input.

## Interface
Parameters:
- `CLK_DIV`, 6: `clk` cycles per SCK half-period; must be ≥1.
- `START_ADDR`, 24'h100000: flash address of byte 0 of the window, above the bitstream.
- `NUM_BYTES`, 16: window length in bytes; must be ≥1.
- `HOLD_CYCLES`, 12000000: `clk` cycles each byte is held before the next fetch (1 s at 12 MHz); must be ≥1.
- `WAKE_WAIT`, 48: `clk` cycles with CS high after the 0xAB wake command (≥ tRES).

Ports:
- `clk`, input, 1: system clock. This is the only clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `spi_cs_n`, output, 1: flash chip select, active-low.
- `spi_sck`, output, 1: SPI clock, mode 0, idle low.
- `spi_mosi`, output, 1: command/address to flash, MSB first.
- `spi_miso`, input, 1: data from flash.
- `led_set`, output, 8: last byte read; feeds the LED driver.
- `byte_valid`, output, 1: one-cycle pulse when `led_set` updates.
- `busy`, output, 1: high while `spi_cs_n` is low.

## Operation
- **Reset values** (all asserted while `rst_n`=0, asynchronously):
  - `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
  - `led_set`=8'hFF (all LEDs off; the LEDs are active-low).
  - `byte_valid`=0, `busy`=0.
  - Byte index = 0; FSM state = WAKE_CMD.
- **States:**
  - WAKE_CMD: one 8-bit transaction shifting out 0xAB. Nothing is captured. Goes to WAKE_WAIT.
  - WAKE_WAIT: `spi_cs_n`=1 for `WAKE_WAIT` cycles. Goes to XFER.
  - XFER: one 40-bit transaction. Shift out 0x03, then the 24-bit address, then 8 dummy bits (`spi_mosi`=0). Capture 8 bits from `spi_miso`, MSB first. Goes to HOLD.
  - HOLD: `spi_cs_n`=1 for `HOLD_CYCLES` cycles. Goes to XFER.
- **Address:** `START_ADDR + index`, truncated to 24 bits.
  - Index width is clog2(`NUM_BYTES`), minimum 1 bit.
  - Index increments when XFER completes and wraps from `NUM_BYTES`-1 to 0. With `NUM_BYTES`=1 the same address is re-read forever.
  - Address overflow past 24'hFFFFFF wraps modulo 2^24.
- **Capture:**
  - `spi_miso` is sampled in the same `clk` edge that drives `spi_sck` from 0 to 1.
  - Only rising edges 33..40 of XFER are captured.
  - The captured byte goes into a shift register. `led_set` changes only at transaction end, never mid-shift.
- **Edges:** `spi_mosi` changes only when `spi_sck` goes 1→0 or when `spi_cs_n` falls. It is stable while `spi_sck`=1.
- **Reset mid-transaction:** `spi_cs_n` returns to 1 asynchronously, ending the flash command. After release the block restarts at WAKE_CMD with index 0. No partial byte reaches `led_set`.
- No flow control from downstream: the LED driver is purely combinational and always accepts.

## Timing
- **Transaction of N bits** (N=8 for wake, 40 for read), with `spi_cs_n` falling at cycle T0:
  - At T0, `spi_mosi` holds bit N-1.
  - `spi_sck` rises at T0+(2k+1)·CLK_DIV and falls at T0+(2k+2)·CLK_DIV, for k = 0..N-1.
  - `spi_cs_n` rises at T0+2N·CLK_DIV, in the same cycle as the final fall of `spi_sck`.
- **Read transaction end** (T0+80·CLK_DIV):
  - `led_set` takes the new byte in that cycle.
  - `byte_valid`=1 for exactly that cycle.
  - `busy` drops in that cycle.
- **After reset release** (first `clk` edge with `rst_n`=1 = cycle 0):
  - `spi_cs_n` falls at cycle 0.
  - The first XFER begins at 16·CLK_DIV + WAKE_WAIT.
- **Read period:** one XFER start to the next is 80·CLK_DIV + HOLD_CYCLES cycles.
- **CS-high time:** minimum is min(WAKE_WAIT, HOLD_CYCLES), which must be ≥ flash tSHSL.

## Test plan
- **Wake sequence:** CLK_DIV=2, WAKE_WAIT=10. Release reset.
  - MOSI decodes to 0xAB over 8 SCK rising edges.
  - `spi_cs_n` high for exactly 10 cycles.
  - Next CS fall at cycle 42.
- **First read:** SPI flash model preloaded with 0x100000=8'hA5, 0x100001=8'h3C.
  - MOSI decodes to 03 10 00 00.
  - `led_set`=8'hA5 with a one-cycle `byte_valid` at CS rise.
  - The next read fetches 0x100001 → 8'h3C.
- **Wrap:** NUM_BYTES=3, HOLD_CYCLES=20.
  - Addresses issued are 100000, 100001, 100002, 100000.
  - Measured period is 80·CLK_DIV+20 = 180 cycles.
- **Single byte:** NUM_BYTES=1. Every read issues 0x100000; `led_set` is unchanged across reads.
- **Mid-transfer reset:** assert `rst_n`=0 after the 20th SCK rise.
  - `spi_cs_n`=1 and `spi_sck`=0 immediately.
  - `led_set`=8'hFF.
  - After release the sequence restarts with 0xAB and address 0x100000.
- **Protocol checker (all runs):**
  - MOSI never toggles while SCK=1.
  - SCK stays 0 while CS=1.
  - `busy` equals the inverse of `spi_cs_n`.
  - `byte_valid` is never high for two consecutive cycles.
